// File: rtl/ide_ata_pio.sv
// Single-transfer ATA/IDE PIO bus master.
// Turns a level-held read/write request into one timed 16-bit IDE cycle:
// address setup, DIOR-/DIOW- strobe, hold, then a one-clock done pulse.
// All bus-facing outputs are registered; the data bus is tri-stated except
// while a write owns it.
module ide_ata_pio #(
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 10,
  parameter int T_HOLD   = 2,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ata_rd,
  input  logic              ata_wr,
  input  logic [4:0]        ata_addr,
  input  logic [DATA_W-1:0] ata_in,
  output logic [DATA_W-1:0] ata_out,
  output logic              ata_done,
  inout  wire  [DATA_W-1:0] ide_data_bus,
  output logic              ide_dior,
  output logic              ide_diow,
  output logic [1:0]        ide_cs,
  output logic [2:0]        ide_da
);

  localparam int MAX_SS  = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
  localparam int CNT_MAX = (MAX_SS > T_HOLD) ? MAX_SS : T_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_read;
  logic [DATA_W-1:0]  wdata;
  logic               drive;

  // The bus is ours only while a write is between setup and hold.
  assign ide_data_bus = drive ? wdata : {DATA_W{1'bz}};

  // Bus-cycle sequencer: one down-counter times SETUP, STROBE and HOLD.
  // DONE behaves like IDLE for request sampling so a held request restarts
  // on the edge that ends DONE (polling without an extra idle clock).
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      ide_dior <= 1'b1;
      ide_diow <= 1'b1;
      ide_cs   <= 2'b11;
      ide_da   <= 3'b000;
      drive    <= 1'b0;
      ata_done <= 1'b0;
      ata_out  <= '0;
    end else begin
      ata_done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          ide_dior <= 1'b1;
          ide_diow <= 1'b1;
          ide_cs   <= 2'b11;
          ide_da   <= 3'b000;
          drive    <= 1'b0;
          state    <= IDLE;
          if (ata_rd || ata_wr) begin
            // Read wins when both requests are raised together.
            is_read <= ata_rd;
            wdata   <= ata_in;
            ide_cs  <= ata_addr[4:3];
            ide_da  <= ata_addr[2:0];
            drive   <= ~ata_rd;
            cnt     <= CNT_W'(T_SETUP - 1);
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            ide_dior <= ~is_read;
            ide_diow <= is_read;
            cnt      <= CNT_W'(T_STROBE - 1);
            state    <= STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            ide_dior <= 1'b1;
            ide_diow <= 1'b1;
            if (is_read) begin
              ata_out <= ide_data_bus;
            end
            cnt   <= CNT_W'(T_HOLD - 1);
            state <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            ide_cs   <= 2'b11;
            ide_da   <= 3'b000;
            drive    <= 1'b0;
            ata_done <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ide_ata_pio.sv
// Self-checking bench for ide_ata_pio: directed scenarios plus randomized
// transactions, each checked cycle by cycle against a timing model derived
// from the cycle-offset rules of the IDE PIO protocol.
module tb_ide_ata_pio;

  localparam int TS  = 2;
  localparam int TST = 10;
  localparam int TH  = 2;
  localparam int TOT = TS + TST + TH;
  localparam logic [15:0] FLOAT = 16'hFFFF;

  logic        clk;
  logic        reset;
  logic        ata_rd;
  logic        ata_wr;
  logic [4:0]  ata_addr;
  logic [15:0] ata_in;
  logic [15:0] ata_out;
  logic        ata_done;
  wire  [15:0] ide_data_bus;
  logic        ide_dior;
  logic        ide_diow;
  logic [1:0]  ide_cs;
  logic [2:0]  ide_da;

  logic [15:0] dev_val;
  logic [15:0] out_model;
  int          errs;
  int          checks;
  int          cyc;
  int          done_cyc;
  int          done_cyc_prev;
  logic        mon_en;

  ide_ata_pio #(.T_SETUP(TS), .T_STROBE(TST), .T_HOLD(TH), .DATA_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .ata_rd       (ata_rd),
    .ata_wr       (ata_wr),
    .ata_addr     (ata_addr),
    .ata_in       (ata_in),
    .ata_out      (ata_out),
    .ata_done     (ata_done),
    .ide_data_bus (ide_data_bus),
    .ide_dior     (ide_dior),
    .ide_diow     (ide_diow),
    .ide_cs       (ide_cs),
    .ide_da       (ide_da)
  );

  // Released bus floats high; the device answers reads while DIOR- is low.
  pullup (ide_data_bus);
  assign ide_data_bus = (!ide_dior) ? dev_val : 16'hzzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Protocol invariants checked every cycle once the bench is running.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("strobes_exclusive", {31'd0, (ide_dior | ide_diow)}, 32'd1);
      chk("strobe_needs_cs", {31'd0, ((ide_dior & ide_diow) | (ide_cs != 2'b11))}, 32'd1);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dior"}, {31'd0, ide_dior}, 32'd1);
    chk({tag, "_diow"}, {31'd0, ide_diow}, 32'd1);
    chk({tag, "_cs"}, {30'd0, ide_cs}, 32'd3);
    chk({tag, "_da"}, {29'd0, ide_da}, 32'd0);
    chk({tag, "_bus"}, {16'd0, ide_data_bus}, {16'd0, FLOAT});
    chk({tag, "_done"}, {31'd0, ata_done}, 32'd0);
    chk({tag, "_out"}, {16'd0, ata_out}, 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_dior"}, {31'd0, ide_dior}, 32'd1);
    chk({tag, "_diow"}, {31'd0, ide_diow}, 32'd1);
    chk({tag, "_cs"}, {30'd0, ide_cs}, 32'd3);
    chk({tag, "_bus"}, {16'd0, ide_data_bus}, {16'd0, FLOAT});
    chk({tag, "_done"}, {31'd0, ata_done}, 32'd0);
    chk({tag, "_out"}, {16'd0, ata_out}, {16'd0, out_model});
  endtask

  // Issue one request at the current negedge and check every clock of the
  // resulting bus cycle by its offset k from the sampling edge E0.
  // abort_k >= 0 raises reset right after the check at that offset.
  task automatic run_txn(input logic rd, input logic wr, input logic [4:0] addr,
                         input logic [15:0] wd, input logic [15:0] dv, input int abort_k);
    logic        strobe;
    logic [15:0] exp_bus;
    logic        stop;
    stop     = 1'b0;
    ata_rd   = rd;
    ata_wr   = wr;
    ata_addr = addr;
    ata_in   = wd;
    dev_val  = dv;
    for (int k = 0; k <= TOT && !stop; k++) begin
      @(negedge clk);
      strobe = (k >= TS) && (k < TS + TST);
      if (rd && k >= TS + TST) out_model = dv;
      if (!rd && k < TOT)      exp_bus = wd;
      else if (rd && strobe)   exp_bus = dv;
      else                     exp_bus = FLOAT;
      chk("cs", {30'd0, ide_cs}, (k < TOT) ? {30'd0, addr[4:3]} : 32'd3);
      chk("da", {29'd0, ide_da}, (k < TOT) ? {29'd0, addr[2:0]} : 32'd0);
      chk("dior", {31'd0, ide_dior}, {31'd0, ~(rd & strobe)});
      chk("diow", {31'd0, ide_diow}, {31'd0, ~(~rd & strobe)});
      chk("bus", {16'd0, ide_data_bus}, {16'd0, exp_bus});
      chk("done", {31'd0, ata_done}, (k == TOT) ? 32'd1 : 32'd0);
      chk("ata_out", {16'd0, ata_out}, {16'd0, out_model});
      if (k == 1) begin
        ata_addr = ~addr;
        ata_in   = ~wd;
      end
      if (k == TOT) begin
        done_cyc_prev = done_cyc;
        done_cyc      = cyc;
        ata_rd        = 1'b0;
        ata_wr        = 1'b0;
      end
      if (k == abort_k) begin
        reset     = 1'b1;
        ata_rd    = 1'b0;
        ata_wr    = 1'b0;
        out_model = 16'h0000;
        stop      = 1'b1;
      end
    end
  endtask

  initial begin
    logic        r;
    logic        w;
    logic [4:0]  a;
    logic [15:0] d;
    logic [15:0] v;
    int          sel;
    errs          = 0;
    checks        = 0;
    cyc           = 0;
    done_cyc      = 0;
    done_cyc_prev = 0;
    mon_en        = 1'b0;
    out_model     = 16'h0000;
    dev_val       = 16'h0000;
    reset         = 1'b1;
    ata_rd        = 1'b1;
    ata_wr        = 1'b0;
    ata_addr      = 5'b10111;
    ata_in        = 16'h0000;

    // Reset with a read request held.
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk_reset_vals("reset_hold_rd");
    reset = 1'b0;

    // Status-register read starting on the first edge after release.
    run_txn(1'b1, 1'b0, 5'b10111, 16'h0000, 16'h0050, -1);
    @(negedge clk);
    chk_idle("after_read");

    // Command-block write.
    run_txn(1'b0, 1'b1, 5'b10110, 16'h0040, 16'h1234, -1);
    @(negedge clk);
    chk_idle("after_write");

    // Control-block write.
    run_txn(1'b0, 1'b1, 5'b01110, 16'h0004, 16'h0000, -1);
    @(negedge clk);
    chk_idle("after_ctl_write");

    // Status polling: request held across three back-to-back reads.
    run_txn(1'b1, 1'b0, 5'b10111, 16'h0000, 16'h0080, -1);
    run_txn(1'b1, 1'b0, 5'b10111, 16'h0000, 16'h00D0, -1);
    chk("poll_spacing_1", done_cyc - done_cyc_prev, TOT + 1);
    run_txn(1'b1, 1'b0, 5'b10111, 16'h0000, 16'h0050, -1);
    chk("poll_spacing_2", done_cyc - done_cyc_prev, TOT + 1);
    @(negedge clk);
    chk_idle("after_poll");

    // Reset during the strobe of a write.
    run_txn(1'b0, 1'b1, 5'b10000, 16'h5A5A, 16'h0000, TS + 3);
    @(negedge clk);
    chk_reset_vals("abort");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, ata_done}, 32'd0);
    end
    chk_idle("after_abort");

    // Randomized transactions with random idle gaps.
    for (int i = 0; i < 10; i++) begin
      sel = int'($urandom_range(0, 2));
      r   = (sel != 0);
      w   = (sel != 1);
      a   = {($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01, 3'($urandom_range(0, 7))};
      d   = 16'($urandom) & 16'h7FFF;
      v   = 16'($urandom) & 16'h7FFF;
      run_txn(r, w, a, d, v, -1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk_idle("rand_gap");
      end
    end

    @(negedge clk);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ide_ata_pio.md
# ide_ata_pio

Single-transfer ATA/IDE PIO bus master. It turns a level-held register read or write request from a controller FSM, such as the RK11 disk emulator, into one correctly timed 16-bit IDE bus cycle. It drives the chip selects, the device address, the DIOR-/DIOW- strobes and the tri-state data bus. It returns a one-cycle completion pulse and holds the read data until the next read completes.

## Interface
- T_SETUP, default 2: clocks from CS/DA valid to strobe assertion (≥1).
- T_STROBE, default 10: clocks the DIOR-/DIOW- strobe is held low (≥1).
- T_HOLD, default 2: clocks from strobe release to CS/DA and write-data release (≥1).

Reset is `reset`, synchronous, active-high. The clock is `clk`.

- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- ata_rd  in  1  read request, level, held by the client until ata_done.
- ata_wr  in  1  write request, level, held by the client until ata_done.
- ata_addr  in  5  {CS[1:0], DA[2:0]} register address. CS bits are active-low: 2'b10 selects the command block, 2'b01 selects the control block.
- ata_in  in  16  write data.
- ata_out  out  16  data from the last completed read (registered).
- ata_done  out  1  one-clock completion pulse.
- ide_data_bus  inout  16  IDE DD[15:0].
- ide_dior  out  1  DIOR-, active-low.
- ide_diow  out  1  DIOW-, active-low.
- ide_cs  out  2  {CS1-, CS0-}, active-low.
- ide_da  out  3  DA[2:0].

## Operation
- FSM states are IDLE, SETUP, STROBE, HOLD and DONE. One down-counter sizes each timed state. Every output is registered.
- **IDLE**
  - Strobes are high, ide_cs=2'b11, ide_da=0 and the bus is high-Z.
  - If ata_rd or ata_wr is high, latch the direction, ata_addr and ata_in, then go to SETUP.
  - If both are high, a read is performed.
- **SETUP**
  - ide_cs=addr[4:3] and ide_da=addr[2:0].
  - For a write, drive the latched data onto ide_data_bus.
  - Stays T_SETUP clocks, then goes to STROBE.
- **STROBE**
  - Assert ide_dior (read) or ide_diow (write) low for T_STROBE clocks.
  - On the edge that leaves STROBE, the read case captures ide_data_bus into ata_out.
  - Goes to HOLD.
- **HOLD**
  - Both strobes are high. CS/DA stay valid, and write data stays driven.
  - Stays T_HOLD clocks, then goes to DONE.
- **DONE**
  - ata_done=1 for exactly this clock. ide_cs=2'b11 and the bus is released.
  - Always returns to IDLE. A request still high there starts a new cycle, so polling is done by the client holding its request.
- ata_out changes only at the read-capture edge. Writes and reset-free idle leave it unchanged.
- The bus is driven only during write SETUP/STROBE/HOLD. In all other states it is high-Z.
- Request inputs are ignored outside IDLE. Changes to ata_addr or ata_in mid-cycle do not affect the bus cycle.

## Timing
- Let E0 be the edge at which IDLE samples a request.
  - CS/DA are valid from E0.
  - The strobe falls at E0+T_SETUP and rises at E0+T_SETUP+T_STROBE; this edge also captures read data.
  - ata_done is high from E0+T_SETUP+T_STROBE+T_HOLD for one clock.
  - With defaults: the strobe is low for 10 clocks and ata_done goes high at E0+14.
- Back-to-back: the next request is sampled at the edge ending DONE. Minimum request-to-request spacing is T_SETUP+T_STROBE+T_HOLD+1 clocks.
- DIOR- and DIOW- are never low simultaneously. A strobe is never low while CS=2'b11.
- Reset values: ide_dior=1, ide_diow=1, ide_cs=2'b11, ide_da=0, bus high-Z, ata_done=0, ata_out=0, FSM=IDLE.
- Reset mid-cycle:
  - Next edge forces the reset values.
  - No ata_done is issued for the aborted cycle.
  - ata_out is cleared.

## Test plan
- Reset with ata_rd=1 held: all outputs take their reset values. After release, a read cycle starts on the first edge and ata_done pulses at E0+14.
- Read, ata_addr=5'b10111, with the device model driving 16'h0050:
  - ide_cs=2'b10 and ide_da=3'b111; dior low for 10 clocks, diow stays high.
  - ata_out=16'h0050 at the done pulse, and still 16'h0050 afterwards.
- Write, ata_addr=5'b10110, ata_in=16'h0040:
  - The bus carries 16'h0040 from E0 through HOLD; diow low for 10 clocks.
  - High-Z in DONE; ata_out unchanged.
- Write to ata_addr=5'b01110 (control block): ide_cs=2'b01 and ide_da=3'b110.
- ata_rd held for 3 transactions (status polling): three done pulses exactly 15 clocks apart, with CS deasserted in each DONE clock.
- Assert reset during STROBE of a write: on the next edge the strobe goes high, the bus goes Z and ide_cs=2'b11. ata_done never pulses.
